// File: rtl/systolic_pkg.sv
// Shared types for the weight-stationary systolic tile sequencer:
// sequencer states, default widths and the per-row west-edge lane bundle.
package systolic_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned PSUM_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        SWITCH,
        STREAM,
        DRAIN
    } seq_state_t;

    // One row's west-edge signals: operand, valid, and the switch pulse.
    typedef struct packed {
        logic signed [DW_DEF-1:0] data;
        logic                     valid;
        logic                     sw;
    } lane_t;

endpackage

// File: rtl/systolic_skew.sv
// DEPTH-stage register delay of one row's lane bundle; all stages clear on reset.
module systolic_skew
    import systolic_pkg::*;
#(
    parameter type         lane_bus_t = lane_t,
    parameter int unsigned DEPTH      = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  lane_bus_t i_lane,
    output lane_bus_t o_lane
);

    lane_bus_t r_pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_lane;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_lane = r_pipe[DEPTH-1];

endmodule

// File: rtl/systolic_seq.sv
// Tile sequencer: loads one weight tile, shifts it into the array, then streams K
// skewed input vectors. Optional perf counters under `SYSTOLIC_SEQ_PERF_EN.
module systolic_seq
    import systolic_pkg::*;
#(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [15:0]          num_vec_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [COLS*DW-1:0]   w_data_i,
    input  logic                 x_valid_i,
    output logic                 x_ready_o,
    input  logic [ROWS*DW-1:0]   x_data_i,
    output logic [COLS*DW-1:0]   arr_weight_o,
    output logic                 arr_accept_w_o,
    output logic [ROWS*DW-1:0]   arr_input_o,
    output logic [ROWS-1:0]      arr_valid_o,
    output logic [ROWS-1:0]      arr_switch_o,
    output logic                 arr_enable_o,
    output logic [31:0]          cycle_cnt_o,
    output logic [31:0]          stall_cnt_o
);

    localparam int unsigned CNT_W = $clog2(ROWS + COLS);

    typedef struct packed {
        logic signed [DW-1:0] data;
        logic                 valid;
        logic                 sw;
    } row_lane_t;

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_rem;
    logic [COLS*DW-1:0] r_buf [ROWS];
    logic               r_enable;
    logic               w_w_fire;
    logic               w_x_fire;
    row_lane_t          w_inj [ROWS];
    row_lane_t          w_out [ROWS];

    always_comb begin
        w_next         = r_state;
        w_ready_o      = 1'b0;
        x_ready_o      = 1'b0;
        arr_weight_o   = '0;
        arr_accept_w_o = 1'b0;
        done_o         = 1'b0;
        w_w_fire       = 1'b0;
        w_x_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) w_next = LOAD;
            end
            LOAD: begin
                w_ready_o = 1'b1;
                w_w_fire  = w_valid_i;
                if (w_valid_i && r_cnt == CNT_W'(ROWS - 1)) w_next = SHIFT;
            end
            SHIFT: begin
                for (int unsigned i = 0; i < ROWS; i++) begin
                    if (r_cnt == CNT_W'(i)) arr_weight_o = r_buf[i];
                end
                if (r_cnt == CNT_W'(ROWS - 1)) begin
                    arr_accept_w_o = 1'b1;
                    w_next         = SWITCH;
                end
            end
            SWITCH: begin
                w_next = (r_rem == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                x_ready_o = 1'b1;
                w_x_fire  = x_valid_i;
                if (x_valid_i && r_rem == 16'd1) w_next = DRAIN;
            end
            DRAIN: begin
                if (r_cnt == CNT_W'(ROWS + COLS - 1)) begin
                    done_o = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // r_cnt serves as beat index (LOAD), shift index (SHIFT) and drain counter (DRAIN).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_enable <= 1'b0;
            for (int unsigned i = 0; i < ROWS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state  <= w_next;
            r_enable <= 1'b1;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_w_fire || r_state == SHIFT || r_state == DRAIN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == IDLE && start_i) begin
                r_rem <= num_vec_i;
            end else if (w_x_fire) begin
                r_rem <= r_rem - 1'b1;
            end
            if (w_w_fire) begin
                for (int unsigned i = 0; i < ROWS; i++) begin
                    if (r_cnt == CNT_W'(i)) r_buf[i] <= w_data_i;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < ROWS; r++) begin
            w_inj[r].data  = w_x_fire ? x_data_i[r*DW +: DW] : '0;
            w_inj[r].valid = w_x_fire;
            w_inj[r].sw    = (r_state == SWITCH);
        end
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        systolic_skew #(
            .lane_bus_t (row_lane_t),
            .DEPTH      (gr + 1)
        ) u_skew (
            .clk    (clk),
            .rst    (rst),
            .i_lane (w_inj[gr]),
            .o_lane (w_out[gr])
        );
        assign arr_input_o[gr*DW +: DW] = w_out[gr].data;
        assign arr_valid_o[gr]          = w_out[gr].valid;
        assign arr_switch_o[gr]         = w_out[gr].sw;
    end

    assign busy_o       = (r_state != IDLE);
    assign arr_enable_o = r_enable;

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == IDLE && start_i) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (busy_o && r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (r_state == STREAM && !x_valid_i && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt_o = r_cycle_cnt;
    assign stall_cnt_o = r_stall_cnt;
`else
    assign cycle_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Randomized self-checking bench for systolic_seq against a timing-rule reference model.
module tb_systolic_seq;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int MAXC = 512;

    logic                 clk;
    logic                 rst;
    logic                 start_i;
    logic [15:0]          num_vec_i;
    logic                 busy_o;
    logic                 done_o;
    logic                 w_valid_i;
    logic                 w_ready_o;
    logic [COLS*DW-1:0]   w_data_i;
    logic                 x_valid_i;
    logic                 x_ready_o;
    logic [ROWS*DW-1:0]   x_data_i;
    logic [COLS*DW-1:0]   arr_weight_o;
    logic                 arr_accept_w_o;
    logic [ROWS*DW-1:0]   arr_input_o;
    logic [ROWS-1:0]      arr_valid_o;
    logic [ROWS-1:0]      arr_switch_o;
    logic                 arr_enable_o;
    logic [31:0]          cycle_cnt_o;
    logic [31:0]          stall_cnt_o;

    systolic_seq #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DW   (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .num_vec_i      (num_vec_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .w_valid_i      (w_valid_i),
        .w_ready_o      (w_ready_o),
        .w_data_i       (w_data_i),
        .x_valid_i      (x_valid_i),
        .x_ready_o      (x_ready_o),
        .x_data_i       (x_data_i),
        .arr_weight_o   (arr_weight_o),
        .arr_accept_w_o (arr_accept_w_o),
        .arr_input_o    (arr_input_o),
        .arr_valid_o    (arr_valid_o),
        .arr_switch_o   (arr_switch_o),
        .arr_enable_o   (arr_enable_o),
        .cycle_cnt_o    (cycle_cnt_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;
    int exp_cyc_tot;
    int exp_stall_tot;
    bit wq[$];
    bit xq[$];
    logic [COLS*DW-1:0] wrow [ROWS];
    logic               inj_v [MAXC];
    logic [ROWS*DW-1:0] inj_d [MAXC];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_idle(input string ph);
        check_eq({ph, "_busy"},   64'(busy_o), 64'(0));
        check_eq({ph, "_done"},   64'(done_o), 64'(0));
        check_eq({ph, "_wrdy"},   64'(w_ready_o), 64'(0));
        check_eq({ph, "_xrdy"},   64'(x_ready_o), 64'(0));
        check_eq({ph, "_valid"},  64'(arr_valid_o), 64'(0));
        check_eq({ph, "_switch"}, 64'(arr_switch_o), 64'(0));
        check_eq({ph, "_input"},  64'(arr_input_o), 64'(0));
        check_eq({ph, "_weight"}, 64'(arr_weight_o), 64'(0));
        check_eq({ph, "_accept"}, 64'(arr_accept_w_o), 64'(0));
        check_eq({ph, "_enable"}, 64'(arr_enable_o), 64'(1));
        check_eq({ph, "_cyccnt"}, 64'(cycle_cnt_o), 64'(exp_cyc_tot));
        check_eq({ph, "_stlcnt"}, 64'(stall_cnt_o), 64'(exp_stall_tot));
    endtask

    task automatic check_reset_outs();
        check_eq("rst_busy",   64'(busy_o), 64'(0));
        check_eq("rst_done",   64'(done_o), 64'(0));
        check_eq("rst_wrdy",   64'(w_ready_o), 64'(0));
        check_eq("rst_xrdy",   64'(x_ready_o), 64'(0));
        check_eq("rst_valid",  64'(arr_valid_o), 64'(0));
        check_eq("rst_switch", 64'(arr_switch_o), 64'(0));
        check_eq("rst_input",  64'(arr_input_o), 64'(0));
        check_eq("rst_weight", 64'(arr_weight_o), 64'(0));
        check_eq("rst_accept", 64'(arr_accept_w_o), 64'(0));
        check_eq("rst_enable", 64'(arr_enable_o), 64'(0));
        check_eq("rst_cyccnt", 64'(cycle_cnt_o), 64'(0));
        check_eq("rst_stlcnt", 64'(stall_cnt_o), 64'(0));
    endtask

    // Cycle 0 issues start; the model tracks the load-complete cycle L, the switch
    // cycle S = L+ROWS+1, handshakes, and done at last-handshake+ROWS+COLS.
    task automatic run_job(input int k, input int abort_at);
        int L, S, done_c, hs, beats, stalls, j, idx;
        bit wv, xv, exp_wready, exp_xready, shifting;
        logic [COLS*DW-1:0] exp_w;
        logic [ROWS-1:0]    exp_valid, exp_sw;
        logic [ROWS*DW-1:0] exp_in, xd;
        for (int i = 0; i < MAXC; i++) begin
            inj_v[i] = 1'b0;
            inj_d[i] = '0;
        end
        @(negedge clk);
        check_idle("idle");
        start_i   = 1'b1;
        num_vec_i = 16'(k);
        w_valid_i = 1'(($urandom % 2));
        w_data_i  = $urandom;
        x_valid_i = 1'(($urandom % 2));
        x_data_i  = $urandom;
        L = -1; S = -1; done_c = -1; hs = 0; beats = 0; stalls = 0;
        for (int c = 1; c < MAXC + 1; c++) begin
            @(negedge clk);
            if (c == MAXC) begin
                n_chk++;
                n_fail++;
                $display("FAIL job_timeout k=%0d cycles=%0d hs=%0d required_done=%0d", k, c, hs, done_c);
                break;
            end
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset_outs();
                @(negedge clk);
                rst       = 1'b0;
                start_i   = 1'b0;
                exp_cyc_tot   = 0;
                exp_stall_tot = 0;
                return;
            end
            exp_wready = (L < 0);
            shifting   = (L >= 0 && c > L && c <= L + ROWS);
            j          = c - L - 1;
            exp_w      = shifting ? wrow[j] : '0;
            if (L >= 0) S = L + ROWS + 1;
            exp_xready = (S >= 0 && c > S && hs < k);
            if (k == 0 && S >= 0) done_c = S + ROWS + COLS;
            for (int r = 0; r < ROWS; r++) begin
                idx = c - 1 - r;
                exp_valid[r]         = (idx >= 0) ? inj_v[idx] : 1'b0;
                exp_in[r*DW +: DW]   = (idx >= 0) ? inj_d[idx][r*DW +: DW] : '0;
                exp_sw[r]            = (S >= 0 && c == S + 1 + r);
            end
            check_eq("busy",   64'(busy_o), 64'(1));
            check_eq("done",   64'(done_o), 64'(c == done_c));
            check_eq("wrdy",   64'(w_ready_o), 64'(exp_wready));
            check_eq("xrdy",   64'(x_ready_o), 64'(exp_xready));
            check_eq("weight", 64'(arr_weight_o), 64'(exp_w));
            check_eq("accept", 64'(arr_accept_w_o), 64'(shifting && j == ROWS - 1));
            check_eq("valid",  64'(arr_valid_o), 64'(exp_valid));
            check_eq("input",  64'(arr_input_o), 64'(exp_in));
            check_eq("switch", 64'(arr_switch_o), 64'(exp_sw));
            check_eq("enable", 64'(arr_enable_o), 64'(1));
`ifdef SYSTOLIC_SEQ_PERF_EN
            check_eq("cyccnt", 64'(cycle_cnt_o), 64'(c - 1));
            check_eq("stlcnt", 64'(stall_cnt_o), 64'(stalls));
`else
            check_eq("cyccnt", 64'(cycle_cnt_o), 64'(0));
            check_eq("stlcnt", 64'(stall_cnt_o), 64'(0));
`endif
            start_i   = (($urandom % 4) == 0) || (c == done_c);
            num_vec_i = 16'($urandom);
            if (exp_wready) wv = (wq.size() > 0) ? wq.pop_front() : 1'(($urandom % 2));
            else            wv = 1'(($urandom % 2));
            w_valid_i = wv;
            w_data_i  = (exp_wready && wv) ? wrow[beats] : $urandom;
            if (exp_wready && wv) begin
                beats++;
                if (beats == ROWS) L = c;
            end
            if (exp_xready) xv = (xq.size() > 0) ? xq.pop_front() : 1'(($urandom % 2));
            else            xv = 1'(($urandom % 2));
            xd        = $urandom;
            x_valid_i = xv;
            x_data_i  = xd;
            if (exp_xready) begin
                if (xv) begin
                    inj_v[c] = 1'b1;
                    inj_d[c] = xd;
                    hs++;
                    if (hs == k) done_c = c + ROWS + COLS;
                end else begin
                    stalls++;
                end
            end
            if (c == done_c) break;
        end
`ifdef SYSTOLIC_SEQ_PERF_EN
        exp_cyc_tot   = done_c;
        exp_stall_tot = stalls;
`endif
    endtask

    task automatic set_ones(input int nw, input int nx);
        wq.delete();
        xq.delete();
        for (int i = 0; i < nw; i++) wq.push_back(1'b1);
        for (int i = 0; i < nx; i++) xq.push_back(1'b1);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_cyc_tot = 0;
        exp_stall_tot = 0;
        rst = 1'b1;
        start_i = 1'b0;
        num_vec_i = '0;
        w_valid_i = 1'b0;
        w_data_i = '0;
        x_valid_i = 1'b0;
        x_data_i = '0;
        #2;
        check_reset_outs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // weight load with a gap between beats 2 and 3; lane values equal beat number
        wq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        xq = '{1'b1, 1'b1};
        for (int r = 0; r < ROWS; r++) wrow[r] = {4{8'(r + 1)}};
        run_job(2, -1);

        // skew alignment, K=3 back-to-back
        for (int r = 0; r < ROWS; r++) wrow[r] = $urandom;
        set_ones(ROWS, 3);
        run_job(3, -1);

        // bubble: two stall cycles between vectors
        set_ones(ROWS, 0);
        xq = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_job(2, -1);

        // K=0
        set_ones(ROWS, 0);
        run_job(0, -1);

        // reset mid-STREAM (L=4, S=9, stream from 10), then a clean job
        set_ones(ROWS, 5);
        run_job(5, 12);
        set_ones(ROWS, 3);
        run_job(3, -1);

        // randomized jobs with random valid gaps
        for (int n = 0; n < 8; n++) begin
            wq.delete();
            xq.delete();
            for (int r = 0; r < ROWS; r++) wrow[r] = $urandom;
            run_job(int'($urandom_range(0, 12)), -1);
        end

        @(negedge clk);
        start_i = 1'b0;
        check_idle("final");
        @(negedge clk);
        check_idle("final2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
